// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Multi-port register file with write-to-read bypass,
//                prioritised write ports, optional hardwired zero register
//                and a per-register write-pending (busy) scoreboard.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk         clock, all state updates on rising edge
//    i_rst_n       asynchronous active-low reset
//    i_rd_addr     NUM_RD packed read addresses
//    o_rd_val      NUM_RD packed read values (bypassed from same-cycle writes)
//    o_rd_busy     per read port: register has an unsatisfied claim
//    i_wr_en       per write port enable (higher index wins on collision)
//    i_wr_addr     NUM_WR packed write addresses
//    i_wr_val      NUM_WR packed write values
//    i_claim_en    request to mark i_claim_addr busy
//    i_claim_addr  register to claim
//    o_claim_ok    claim accepted this cycle (combinational)
//    o_busy_cnt    number of busy registers (registered)
// ============================================================================
module reg_file_sb #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]      o_rd_val,
  output logic [NUM_RD-1:0]                o_rd_busy,
  input  logic [NUM_WR-1:0]                i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]     i_wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0]      i_wr_val,
  input  logic                             i_claim_en,
  input  logic [ADDR_WIDTH-1:0]            i_claim_addr,
  output logic                             o_claim_ok,
  output logic [ADDR_WIDTH:0]              o_busy_cnt
);

  localparam int c_num_regs = 2**ADDR_WIDTH;

  logic [REG_WIDTH-1:0]  r_regs [c_num_regs];
  logic [c_num_regs-1:0] r_busy;
  logic [ADDR_WIDTH:0]   r_busy_cnt;

  logic [c_num_regs-1:0] w_wr_hit;
  logic [REG_WIDTH-1:0]  w_wr_data [c_num_regs];
  logic [c_num_regs-1:0] w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_rel_cnt;
  logic                  w_claim_zero;
  logic                  w_claim_ok;
  logic                  w_claim_set;

  // Per-address write decode. Ports are scanned in ascending order so the
  // highest-index enabled port targeting an address supplies its data.
  always_comb begin
    for (int a = 0; a < c_num_regs; a++) begin
      w_wr_hit[a]  = 1'b0;
      w_wr_data[a] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (i_wr_en[p] && (i_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a))) begin
          w_wr_hit[a]  = 1'b1;
          w_wr_data[a] = i_wr_val[p*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  // A busy register may be re-claimed in the same cycle its writeback
  // arrives; the zero register is always claimable but never tracked.
  assign w_claim_zero = (ZERO_REG != 0) && (i_claim_addr == '0);
  assign w_claim_ok   = i_rst_n && i_claim_en &&
                        (w_claim_zero || !r_busy[i_claim_addr] || w_wr_hit[i_claim_addr]);
  assign w_claim_set  = w_claim_ok && !w_claim_zero;
  assign o_claim_ok   = w_claim_ok;

  // Release first, then claim, so a same-cycle claim leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wr_hit;
    if (w_claim_set) begin
      w_busy_nxt[i_claim_addr] = 1'b1;
    end
  end

  // Only bits that actually fall from 1 to 0 decrement the counter.
  always_comb begin
    w_rel_cnt = '0;
    for (int a = 0; a < c_num_regs; a++) begin
      w_rel_cnt = w_rel_cnt + {{ADDR_WIDTH{1'b0}}, (r_busy[a] & w_wr_hit[a])};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int a = 0; a < c_num_regs; a++) begin
        r_regs[a] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int a = 0; a < c_num_regs; a++) begin
        if (w_wr_hit[a] && !((ZERO_REG != 0) && (a == 0))) begin
          r_regs[a] <= w_wr_data[a];
        end
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= r_busy_cnt + {{ADDR_WIDTH{1'b0}}, w_claim_set} - w_rel_cnt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  // Read ports: bypass is gated by reset so nothing leaks while it is held.
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_addr;
      logic                  w_zero;

      assign w_addr = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

      assign o_rd_val[k*REG_WIDTH +: REG_WIDTH] =
          (!i_rst_n || w_zero)  ? '0 :
          w_wr_hit[w_addr]      ? w_wr_data[w_addr] :
                                  r_regs[w_addr];

      assign o_rd_busy[k] = i_rst_n && !w_zero && r_busy[w_addr] && !w_wr_hit[w_addr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_sb
//  Description : Self-checking bench for reg_file_sb: directed scenarios with
//                literal expectations plus randomized traffic compared each
//                cycle against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int RW    = 32;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int ZR    = 1;
  localparam int NREGS = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*RW-1:0]  rd_val;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*RW-1:0]  wr_val;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic              claim_ok;
  logic [AW:0]       busy_cnt;

  always #5 clk = ~clk;

  reg_file_sb #(
    .REG_WIDTH (RW),
    .ADDR_WIDTH(AW),
    .NUM_RD    (NR),
    .NUM_WR    (NW),
    .ZERO_REG  (ZR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rd_addr   (rd_addr),
    .o_rd_val    (rd_val),
    .o_rd_busy   (rd_busy),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_val    (wr_val),
    .i_claim_en  (claim_en),
    .i_claim_addr(claim_addr),
    .o_claim_ok  (claim_ok),
    .o_busy_cnt  (busy_cnt)
  );

  // Reference model: plain arrays updated by the architectural rules.
  logic [RW-1:0] m_mem  [NREGS];
  bit            m_busy [NREGS];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_zero(input int a);
    return (ZR != 0) && (a == 0);
  endfunction

  function automatic bit any_wr(input int a);
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] exp_val(input int a);
    logic [RW-1:0] v;
    if (!rst_n || is_zero(a)) return '0;
    v = m_mem[a];
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == a)) v = wr_val[p*RW +: RW];
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    return rst_n && !is_zero(a) && m_busy[a] && !any_wr(a);
  endfunction

  function automatic bit exp_claim();
    int ca = int'(claim_addr);
    return rst_n && claim_en && (is_zero(ca) || !m_busy[ca] || any_wr(ca));
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    if (!rst_n) return 0;
    for (int a = 0; a < NREGS; a++) c += int'(m_busy[a]);
    return c;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < NREGS; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic model_update();
    bit ok;
    int a;
    if (!rst_n) return;
    ok = exp_claim();
    for (int p = 0; p < NW; p++) begin
      if (wr_en[p]) begin
        a = int'(wr_addr[p*AW +: AW]);
        if (!is_zero(a)) m_mem[a] = wr_val[p*RW +: RW];
        m_busy[a] = 1'b0;
      end
    end
    if (ok && !is_zero(int'(claim_addr))) m_busy[int'(claim_addr)] = 1'b1;
  endtask

  // The single per-cycle compare of every output against the model.
  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      int a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("rd_val[%0d] addr %0d", k, a), 64'(rd_val[k*RW +: RW]), 64'(exp_val(a)));
      chk($sformatf("rd_busy[%0d] addr %0d", k, a), 64'(rd_busy[k]), 64'(exp_busy(a)));
    end
    chk("claim_ok", 64'(claim_ok), 64'(exp_claim()));
    chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    claim_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [RW-1:0] v);
    wr_en[p]               = 1'b1;
    wr_addr[p*AW +: AW]    = AW'(a);
    wr_val[p*RW +: RW]     = v;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_claim(input int a);
    claim_en   = 1'b1;
    claim_addr = AW'(a);
  endtask

  initial begin
    rst_n = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_val = '0;
    claim_en = 1'b0; claim_addr = '0;
    model_clear();
    #1 rst_n = 1'b0;

    // Reset held: traffic must be ignored.
    set_wr(0, 5, 32'h1234); set_wr(1, 6, 32'h5678); set_claim(3);
    set_rd(0, 5); set_rd(1, 3);
    settle();
    chk("rst rd_val0", 64'(rd_val[31:0]), 64'h0);
    chk("rst rd_busy", 64'(rd_busy), 64'h0);
    chk("rst claim_ok", 64'(claim_ok), 64'h0);
    chk("rst busy_cnt", 64'(busy_cnt), 64'h0);
    tick(); tick();
    idle(); rst_n = 1'b1;
    settle();
    chk("post-rst rd 5", 64'(rd_val[31:0]), 64'h0);
    tick();

    // Bypass and write-port priority.
    set_wr(0, 5, 32'h1111); set_wr(1, 5, 32'h2222); set_rd(0, 5);
    settle();
    chk("bypass prio", 64'(rd_val[31:0]), 64'h2222);
    tick();
    idle();
    settle();
    chk("stored prio", 64'(rd_val[31:0]), 64'h2222);
    tick();
    set_wr(0, 0, 32'hFFFF); set_rd(0, 0);
    settle();
    chk("zero bypass", 64'(rd_val[31:0]), 64'h0);
    tick();
    idle();
    settle();
    chk("zero stored", 64'(rd_val[31:0]), 64'h0);
    tick();

    // Scoreboard claim / reject / release.
    set_claim(3); set_rd(1, 3);
    settle();
    chk("claim3 ok", 64'(claim_ok), 64'h1);
    tick();
    idle();
    settle();
    chk("claim3 busy", 64'(rd_busy[1]), 64'h1);
    chk("claim3 cnt", 64'(busy_cnt), 64'h1);
    tick();
    set_claim(3);
    settle();
    chk("reclaim3 rejected", 64'(claim_ok), 64'h0);
    tick();
    idle(); set_wr(0, 3, 32'hABCD);
    settle();
    chk("release3 busy", 64'(rd_busy[1]), 64'h0);
    chk("release3 val", 64'(rd_val[63:32]), 64'hABCD);
    chk("release3 cnt before", 64'(busy_cnt), 64'h1);
    tick();
    idle();
    settle();
    chk("release3 cnt", 64'(busy_cnt), 64'h0);
    tick();

    // Simultaneous release and claim of a busy register.
    set_claim(7); set_rd(1, 7);
    settle(); tick();
    idle(); set_wr(1, 7, 32'h77); set_claim(7);
    settle();
    chk("simul claim_ok", 64'(claim_ok), 64'h1);
    tick();
    idle();
    settle();
    chk("simul busy7", 64'(rd_busy[1]), 64'h1);
    chk("simul cnt", 64'(busy_cnt), 64'h1);
    tick();
    set_wr(0, 7, 32'h0);
    settle(); tick();

    // Fill the scoreboard, then dual release plus claim.
    idle();
    for (int a = 1; a < NREGS; a++) begin
      set_claim(a);
      settle(); tick();
    end
    idle();
    settle();
    chk("full cnt", 64'(busy_cnt), 64'd15);
    tick();
    set_wr(0, 1, 32'h101); set_wr(1, 2, 32'h202); set_claim(2);
    settle(); tick();
    idle();
    settle();
    chk("dual rel cnt", 64'(busy_cnt), 64'd14);
    tick();

    // Drain, claim four, then reset asynchronously mid-cycle.
    for (int a = 1; a < NREGS; a += 2) begin
      idle(); set_wr(0, a, 32'(a));
      if (a + 1 < NREGS) set_wr(1, a + 1, 32'(a + 1));
      settle(); tick();
    end
    foreach (m_busy[i]) if (m_busy[i]) chk("drain", 64'(i), 64'hFFFF);
    idle();
    for (int i = 0; i < 4; i++) begin
      set_claim(4 + 2 * i);
      settle(); tick();
    end
    idle(); set_rd(0, 4); set_rd(1, 10);
    settle();
    chk("four busy cnt", 64'(busy_cnt), 64'd4);
    chk("four busy rd", 64'(rd_busy), 64'h3);
    @(posedge clk); model_update(); #3;
    set_claim(9); set_wr(0, 4, 32'h44);
    rst_n = 1'b0; model_clear();
    #1;
    chk("async cnt", 64'(busy_cnt), 64'h0);
    chk("async busy", 64'(rd_busy), 64'h0);
    chk("async claim", 64'(claim_ok), 64'h0);
    chk("async rd", 64'(rd_val), 64'h0);
    settle(); tick();
    idle(); rst_n = 1'b1;
    settle(); tick();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_clear();
      end
      for (int p = 0; p < NW; p++) begin
        wr_en[p] = ($urandom_range(0, 2) == 0);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 15));
        wr_val[p*RW +: RW]  = RW'($urandom);
      end
      for (int k = 0; k < NR; k++)
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 15));
      claim_en   = ($urandom_range(0, 4) < 3);
      claim_addr = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 15));
      settle(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
